// File: rtl/schmidl_cox_detector_if.sv
// AXI-Stream bundle for the Schmidl-Cox detector: one instance per stream
// direction. The master drives data/valid/last, the slave drives ready.
interface schmidl_cox_detector_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/schmidl_cox_detector.sv
// Schmidl-Cox preamble detector. A 2*DELAY_L delay line feeds running sums of
// the lag-DELAY_L autocorrelation P and the window energy E; the metric
// |Re P| + |Im P| is compared against E scaled by cfg_threshold, and a
// SEARCH/PLATEAU/FRAME/WAIT_LOW FSM gates the output stream.
// Three-stage pipeline (products, sums, metric/FSM/output), stalled as a whole
// by output backpressure.
// Optional feature: define SCHMIDL_COX_DETECT_CNT_EN to build the saturating
// detection counter behind status_detect_count; otherwise it is tied to zero.
module schmidl_cox_detector #(
    parameter int SAMPLE_W    = 16,
    parameter int DELAY_L     = 64,
    parameter int MIN_PLATEAU = 16,
    parameter int PKT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    schmidl_cox_detector_if.slave  s_axis,
    schmidl_cox_detector_if.master m_axis,
    input  logic [PKT_W-1:0]       cfg_packet_size,
    input  logic [15:0]            cfg_threshold,
    input  logic [1:0]             cfg_output_select,
    output logic                   detect_pulse,
    output logic [31:0]            status_detect_count
);
    localparam int LOG_L  = $clog2(DELAY_L);
    localparam int PROD_W = 2*SAMPLE_W + 1;          // one complex MAC term
    localparam int DP_W   = PROD_W + 1;              // add-new minus drop-old
    localparam int ACC_W  = 2*SAMPLE_W + LOG_L + 1;  // running sums P and E
    localparam int WARM_W = LOG_L + 2;               // holds 2*DELAY_L
    localparam int RUN_W  = 8;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] i;
        logic signed [SAMPLE_W-1:0] q;
    } sample_t;

    typedef enum logic [1:0] {SEARCH, PLATEAU, FRAME, WAIT_LOW} state_t;

    function automatic logic signed [PROD_W-1:0] mul(input logic signed [SAMPLE_W-1:0] a,
                                                     input logic signed [SAMPLE_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    logic enable;
    assign enable        = !m_axis.tvalid || m_axis.tready;
    assign s_axis.tready = enable;

    // ---------------- stage 1: delay line and per-sample sum corrections
    sample_t                  dline [2*DELAY_L];
    sample_t                  x_new, x_mid, x_old;
    logic signed [PROD_W-1:0] p_new_re, p_new_im, p_old_re, p_old_im, e_new, e_old;
    logic                     s1_valid;
    sample_t                  s1_x;
    logic signed [DP_W-1:0]   s1_dp_re, s1_dp_im, s1_de;

    assign x_new = s_axis.tdata;
    assign x_mid = dline[DELAY_L-1];
    assign x_old = dline[2*DELAY_L-1];

    // Entering term x(k-L)*conj(x(k)) and leaving term x(k-2L)*conj(x(k-L)), plus energies
    always_comb begin
        p_new_re = mul(x_mid.i, x_new.i) + mul(x_mid.q, x_new.q);
        p_new_im = mul(x_mid.q, x_new.i) - mul(x_mid.i, x_new.q);
        p_old_re = mul(x_old.i, x_mid.i) + mul(x_old.q, x_mid.q);
        p_old_im = mul(x_old.q, x_mid.i) - mul(x_old.i, x_mid.q);
        e_new    = mul(x_new.i, x_new.i) + mul(x_new.q, x_new.q);
        e_old    = mul(x_mid.i, x_mid.i) + mul(x_mid.q, x_mid.q);
    end

    // Shift the delay line and register the sum corrections on each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the delay line is cleared too, otherwise the first 2*DELAY_L
            // samples after reset would subtract stale history from the sums.
            for (int i = 0; i < 2*DELAY_L; i++) dline[i] <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_dp_re <= '0;
            s1_dp_im <= '0;
            s1_de    <= '0;
        end else if (enable) begin
            s1_valid <= s_axis.tvalid;
            if (s_axis.tvalid) begin
                dline[0] <= x_new;
                for (int i = 1; i < 2*DELAY_L; i++) dline[i] <= dline[i-1];
                s1_x     <= x_new;
                s1_dp_re <= DP_W'(p_new_re) - DP_W'(p_old_re);
                s1_dp_im <= DP_W'(p_new_im) - DP_W'(p_old_im);
                s1_de    <= DP_W'(e_new) - DP_W'(e_old);
            end
        end
    end

    // ---------------- stage 2: running sums and warm-up count
    logic                    s2_valid;
    sample_t                 s2_x;
    logic signed [ACC_W-1:0] p_re, p_im, e_acc;
    logic [WARM_W-1:0]       warm_cnt;

    // Add-new/subtract-old update of P and E; warm_cnt counts samples into the sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            p_re     <= '0;
            p_im     <= '0;
            e_acc    <= '0;
            warm_cnt <= '0;
        end else if (enable) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x  <= s1_x;
                p_re  <= p_re + ACC_W'(s1_dp_re);
                p_im  <= p_im + ACC_W'(s1_dp_im);
                e_acc <= e_acc + ACC_W'(s1_de);
                if (warm_cnt != WARM_W'(2*DELAY_L)) warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

    // ---------------- stage 3: metric, decision, FSM and output register
    state_t             state;
    logic [RUN_W-1:0]   run;
    logic [PKT_W-1:0]   frame_len, frame_cnt, beat_cnt, pkt_len;
    logic [ACC_W-1:0]   abs_re, abs_im, thr_level;
    logic [ACC_W:0]     metric;
    logic [ACC_W+15:0]  e_scaled;
    logic [63:0]        metric_64;
    logic               above, in_frame, frame_last, beat_last, plateau_hit, emit, out_last;
    logic [31:0]        out_word;

    // Detection decision and output word selection for the sample in stage 2
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        out_word    = '0;
        out_last    = 1'b0;
        abs_re      = p_re[ACC_W-1] ? -p_re : p_re;
        abs_im      = p_im[ACC_W-1] ? -p_im : p_im;
        metric      = {1'b0, abs_re} + {1'b0, abs_im};
        metric_64   = 64'(metric);
        e_scaled    = (ACC_W+16)'(e_acc) * (ACC_W+16)'(cfg_threshold);
        thr_level   = ACC_W'(e_scaled >> 16);
        above       = (metric >= {1'b0, thr_level}) && (e_acc != '0) &&
                      (warm_cnt == WARM_W'(2*DELAY_L));
        pkt_len     = (cfg_packet_size == '0) ? PKT_W'(1) : cfg_packet_size;
        in_frame    = (state == FRAME);
        frame_last  = in_frame && (frame_cnt == frame_len - PKT_W'(1));
        beat_last   = (beat_cnt >= pkt_len - PKT_W'(1));
        plateau_hit = above && (((state == SEARCH) && (MIN_PLATEAU == 1)) ||
                                ((state == PLATEAU) && (run == RUN_W'(MIN_PLATEAU - 1))));
        emit        = (cfg_output_select != 2'd1) || in_frame;
        case (cfg_output_select)
            2'd0: begin out_word = in_frame ? 32'(s2_x) : 32'd0; out_last = beat_last;  end
            2'd1: begin out_word = 32'(s2_x);                   out_last = frame_last; end
            2'd2: begin out_word = metric_64[63:32];            out_last = beat_last;  end
            default: begin out_word = metric_64[31:0];          out_last = beat_last;  end
        endcase
    end

    // Detection FSM and registered stream outputs, advanced once per sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            run           <= '0;
            frame_len     <= PKT_W'(1);
            frame_cnt     <= '0;
            beat_cnt      <= '0;
            detect_pulse  <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            detect_pulse <= 1'b0;
            if (enable) begin
                m_axis.tvalid <= s2_valid && emit;
                if (s2_valid) begin
                    m_axis.tdata <= out_word;
                    m_axis.tlast <= out_last;
                    if (cfg_output_select != 2'd1)
                        beat_cnt <= beat_last ? '0 : beat_cnt + PKT_W'(1);
                    if (plateau_hit) begin
                        state        <= FRAME;
                        frame_len    <= pkt_len;
                        frame_cnt    <= '0;
                        detect_pulse <= 1'b1;
                    end else begin
                        case (state)
                            SEARCH:   if (above) begin state <= PLATEAU; run <= RUN_W'(1); end
                            PLATEAU:  if (!above) state <= SEARCH; else run <= run + RUN_W'(1);
                            FRAME: begin
                                frame_cnt <= frame_cnt + PKT_W'(1);
                                if (frame_last) state <= WAIT_LOW;
                            end
                            default:  if (!above) state <= SEARCH;
                        endcase
                    end
                end
            end
        end
    end

`ifdef SCHMIDL_COX_DETECT_CNT_EN
    // Saturating count of detections
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status_detect_count <= '0;
        else if (detect_pulse && (status_detect_count != 32'hFFFF_FFFF))
            status_detect_count <= status_detect_count + 32'd1;
    end
`else
    assign status_detect_count = '0;
`endif
endmodule

// File: tb/tb_schmidl_cox_detector.sv
// Directed bench for schmidl_cox_detector (default parameters: 16-bit I/Q,
// DELAY_L = 64, MIN_PLATEAU = 16). Expected values are hand-derived from the
// detector's definition; a negedge monitor collects output beats and pulses.
module tb_schmidl_cox_detector;
    localparam logic [31:0] C_ONE = 32'h0100_0000;  // I = 0x0100, Q = 0
    localparam logic [31:0] C_MAX = 32'h8000_8000;  // I = Q = -32768

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_packet_size = 16'd256;
    logic [15:0] cfg_threshold = 16'h8000;
    logic [1:0]  cfg_output_select = 2'd0;
    logic        detect_pulse;
    logic [31:0] status_detect_count;

    schmidl_cox_detector_if #(.DATA_W(32)) s_if ();
    schmidl_cox_detector_if #(.DATA_W(32)) m_if ();

    schmidl_cox_detector dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis              (s_if),
        .m_axis              (m_if),
        .cfg_packet_size     (cfg_packet_size),
        .cfg_threshold       (cfg_threshold),
        .cfg_output_select   (cfg_output_select),
        .detect_pulse        (detect_pulse),
        .status_detect_count (status_detect_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          stall_en = 1'b0;
    logic [32:0] beats [$];   // {tlast, tdata}
    int          pulse_cnt = 0;
    int          pulse_beat = -1;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_if.tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (detect_pulse) begin
                pulse_cnt++;
                pulse_beat = beats.size();
            end
            if (m_if.tvalid && m_if.tready) beats.push_back({m_if.tlast, m_if.tdata});
        end
    end

    task automatic clear_mon();
        beats.delete();
        pulse_cnt  = 0;
        pulse_beat = -1;
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic send(input logic [31:0] d);
        bit acc = 1'b0;
        int waited = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 500) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: not accepted after %0d cycles, acceptance required", waited);
                acc = 1'b1;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n_last;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b want=0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b want=0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata got=%h want=0", m_if.tdata); end
        n_vec++; if (detect_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got=%b want=0", detect_pulse); end
        n_vec++; if (status_detect_count !== 32'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", status_detect_count); end
        @(posedge clk); #1 rst = 1'b0;
        clear_mon();
        // Start a frame, then reset in the middle of it
        cfg_output_select = 2'd1; cfg_threshold = 16'h8000; cfg_packet_size = 16'd256;
        for (int i = 0; i < 200; i++) send(C_ONE);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid got=%b want=0", m_if.tvalid); end
        n_vec++; if (detect_pulse !== 1'b0) begin n_err++; $display("FAIL midrst_pulse got=%b want=0", detect_pulse); end
        n_vec++; if (beats.size() != 54) begin n_err++; $display("FAIL midrst_beats got=%0d want=54", beats.size()); end
        n_last = 0;
        foreach (beats[i]) if (beats[i][32]) n_last++;
        n_vec++; if (n_last != 0) begin n_err++; $display("FAIL midrst_no_tlast got=%0d want=0", n_last); end
        @(posedge clk); #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_next_tvalid got=%b want=0", m_if.tvalid); end
        rst = 1'b0;
        clear_mon();
        // One sample after release: presented on the third enabled edge
        cfg_output_select = 2'd0;
        s_if.tdata = C_ONE; s_if.tvalid = 1'b1;
        @(posedge clk); #1 s_if.tvalid = 1'b0;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL lat_edge1 got=%b want=0", m_if.tvalid); end
        @(posedge clk); #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL lat_edge2 got=%b want=0", m_if.tvalid); end
        @(posedge clk); #1;
        n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL lat_edge3 got=%b want=1", m_if.tvalid); end
        n_vec++; if (m_if.tdata !== 32'd0) begin n_err++; $display("FAIL lat_data got=%h want=0", m_if.tdata); end
    endtask

    task automatic test_zero_input();
        int n_nz, n_badlast;
        do_reset();
        cfg_output_select = 2'd0; cfg_packet_size = 16'd100; cfg_threshold = 16'h8000;
        for (int i = 0; i < 1000; i++) send(32'd0);
        drain(10);
        n_nz = 0; n_badlast = 0;
        foreach (beats[i]) begin
            if (beats[i][31:0] != 32'd0) n_nz++;
            if (beats[i][32] != ((i % 100) == 99)) n_badlast++;
        end
        n_vec++; if (beats.size() != 1000) begin n_err++; $display("FAIL zero_beats got=%0d want=1000", beats.size()); end
        n_vec++; if (n_nz != 0) begin n_err++; $display("FAIL zero_data nonzero=%0d want=0", n_nz); end
        n_vec++; if (n_badlast != 0) begin n_err++; $display("FAIL zero_tlast misplaced=%0d want=0", n_badlast); end
        n_vec++; if (pulse_cnt != 0) begin n_err++; $display("FAIL zero_pulse got=%0d want=0", pulse_cnt); end
    endtask

    // Constant input: M grows by one term per sample from sample 64 on, full after 127
    task automatic test_constant(input logic [31:0] smp, input logic [1:0] mode,
                                 input logic [31:0] exp_b64, input logic [31:0] exp_full);
        int n_bad;
        do_reset();
        cfg_output_select = mode; cfg_packet_size = 16'd1000; cfg_threshold = 16'h8000;
        for (int i = 0; i < 300; i++) send(smp);
        drain(10);
        n_vec++; if (beats.size() != 300) begin n_err++; $display("FAIL const_m%0d_beats got=%0d want=300", mode, beats.size()); end
        if (beats.size() == 300) begin
            n_vec++; if (beats[0][31:0] != 32'd0) begin n_err++; $display("FAIL const_m%0d_b0 got=%h want=0", mode, beats[0][31:0]); end
            n_vec++; if (beats[64][31:0] != exp_b64) begin n_err++; $display("FAIL const_m%0d_b64 got=%h want=%h", mode, beats[64][31:0], exp_b64); end
            n_bad = 0;
            for (int i = 127; i < 300; i++) if (beats[i][31:0] != exp_full) n_bad++;
            n_vec++; if (n_bad != 0) begin n_err++; $display("FAIL const_m%0d_full bad=%0d want=0 (value %h)", mode, n_bad, exp_full); end
        end
    endtask

    task automatic test_detect();
        int n_last, n_bad, first_nz, last_nz, n_nz;
        do_reset();
        cfg_output_select = 2'd1; cfg_packet_size = 16'd256; cfg_threshold = 16'h8000;
        for (int i = 0; i < 600; i++) begin
            if (i == 200) cfg_packet_size = 16'd5;  // latched length must hold
            send(C_ONE);
        end
        drain(10);
        cfg_packet_size = 16'd256;
        n_last = 0; n_bad = 0;
        foreach (beats[i]) begin
            if (beats[i][32]) n_last++;
            if (beats[i][31:0] != C_ONE) n_bad++;
        end
        n_vec++; if (beats.size() != 256) begin n_err++; $display("FAIL det_beats got=%0d want=256", beats.size()); end
        n_vec++; if (n_last != 1) begin n_err++; $display("FAIL det_tlast_count got=%0d want=1", n_last); end
        if (beats.size() == 256) begin
            n_vec++; if (beats[255][32] !== 1'b1) begin n_err++; $display("FAIL det_tlast_pos got=%b want=1", beats[255][32]); end
        end
        n_vec++; if (n_bad != 0) begin n_err++; $display("FAIL det_data bad=%0d want=0", n_bad); end
        n_vec++; if (pulse_cnt != 1) begin n_err++; $display("FAIL det_pulses got=%0d want=1", pulse_cnt); end
        n_vec++; if (status_detect_count !== exp_cnt) begin n_err++; $display("FAIL det_count got=%0d want=%0d", status_detect_count, exp_cnt); end
        // Same stream in mode 0: pulse with beat 142, frame covers beats 143..398
        do_reset();
        cfg_output_select = 2'd0;
        for (int i = 0; i < 500; i++) send(C_ONE);
        drain(10);
        first_nz = -1; last_nz = -1; n_nz = 0; n_last = 0;
        foreach (beats[i]) begin
            if (beats[i][31:0] != 32'd0) begin
                if (first_nz < 0) first_nz = i;
                last_nz = i; n_nz++;
            end
            if (beats[i][32]) n_last++;
        end
        n_vec++; if (pulse_beat != 142) begin n_err++; $display("FAIL det_pulse_beat got=%0d want=142", pulse_beat); end
        n_vec++; if (first_nz != 143) begin n_err++; $display("FAIL det_first_frame got=%0d want=143", first_nz); end
        n_vec++; if (last_nz != 398) begin n_err++; $display("FAIL det_last_frame got=%0d want=398", last_nz); end
        n_vec++; if (n_nz != 256) begin n_err++; $display("FAIL det_frame_len got=%0d want=256", n_nz); end
        n_vec++; if (n_last != 1) begin n_err++; $display("FAIL det_m0_tlast got=%0d want=1", n_last); end
        if (beats.size() == 500) begin
            n_vec++; if (beats[255][32] !== 1'b1) begin n_err++; $display("FAIL det_m0_tlast_pos got=%b want=1", beats[255][32]); end
        end
    endtask

    task automatic test_no_detect();
        do_reset();
        cfg_output_select = 2'd1; cfg_threshold = 16'hFFFF; cfg_packet_size = 16'd64;
        for (int i = 0; i < 500; i++) send($urandom());
        drain(10);
        n_vec++; if (pulse_cnt != 0) begin n_err++; $display("FAIL nodet_pulses got=%0d want=0", pulse_cnt); end
        n_vec++; if (beats.size() != 0) begin n_err++; $display("FAIL nodet_beats got=%0d want=0", beats.size()); end
        cfg_threshold = 16'h8000;
    endtask

    task automatic test_backpressure();
        logic [31:0] vec [456];
        logic [32:0] ref_q [$];
        int n_diff;
        for (int i = 0; i < 64; i++) vec[i] = $urandom();
        for (int i = 64; i < 256; i++) vec[i] = vec[i - 64];
        for (int i = 256; i < 456; i++) vec[i] = $urandom();
        cfg_output_select = 2'd0; cfg_packet_size = 16'd50; cfg_threshold = 16'h8000;
        stall_en = 1'b0;
        do_reset();
        foreach (vec[i]) send(vec[i]);
        drain(20);
        ref_q = beats;
        n_vec++; if (ref_q.size() != 456) begin n_err++; $display("FAIL bp_ref_beats got=%0d want=456", ref_q.size()); end
        n_vec++; if (pulse_beat != 142) begin n_err++; $display("FAIL bp_ref_pulse got=%0d want=142", pulse_beat); end
        stall_en = 1'b1;
        do_reset();
        foreach (vec[i]) send(vec[i]);
        drain(80);
        stall_en = 1'b0;
        drain(5);
        n_vec++; if (beats.size() != 456) begin n_err++; $display("FAIL bp_beats got=%0d want=456", beats.size()); end
        n_vec++; if (pulse_beat != 142) begin n_err++; $display("FAIL bp_pulse got=%0d want=142", pulse_beat); end
        n_diff = 0;
        if (beats.size() == ref_q.size())
            foreach (ref_q[i]) if (beats[i] !== ref_q[i]) n_diff++;
        n_vec++; if (n_diff != 0) begin n_err++; $display("FAIL bp_sequence differing=%0d want=0", n_diff); end
    endtask

    initial begin
`ifdef SCHMIDL_COX_DETECT_CNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        test_reset();
        test_zero_input();
        test_constant(C_ONE, 2'd3, 32'h0001_0000, 32'h0040_0000);
        test_constant(C_ONE, 2'd2, 32'h0000_0000, 32'h0000_0000);
        test_constant(C_MAX, 2'd2, 32'h0000_0000, 32'h0000_0020);
        test_detect();
        test_no_detect();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/schmidl_cox_detector.md
SCHMIDL_COX_DETECTOR -- requirements
Module: schmidl_cox_detector

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: bit width of each of the signed I and Q components.
REQ-002 SHALL have parameter DELAY_L, default 64: half-preamble length in samples; power of 2, range 8..1024.
REQ-003 SHALL have parameter MIN_PLATEAU, default 16: number of consecutive above-threshold samples that triggers a detection; range 1..255.
REQ-004 SHALL have parameter PKT_W, default 16: width of the frame-length configuration input.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 SHALL have port s_axis_tdata, input, 2*SAMPLE_W bits: input sample packed {I,Q}, I in the upper half.
REQ-008 SHALL have ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1): input AXI-Stream handshake.
REQ-009 SHALL have port m_axis_tdata, output, 32 bits: output sample or metric word.
REQ-010 SHALL have ports m_axis_tlast, m_axis_tvalid (outputs, 1) and m_axis_tready (input, 1): output AXI-Stream handshake.
REQ-011 SHALL have port cfg_packet_size, input, PKT_W bits: frame length in samples; a value of 0 is treated as 1.
REQ-012 SHALL have port cfg_threshold, input, 16 bits: unsigned Q0.16 detection ratio.
REQ-013 SHALL have port cfg_output_select, input, 2 bits: output mode.
REQ-014 SHALL have port detect_pulse, output, 1 bit: one-cycle pulse on each FRAME entry.
REQ-015 SHALL have port status_detect_count, output, 32 bits: detection counter (see REQ-031).

Function
REQ-016 SHALL stall the whole pipeline with enable = !m_axis_tvalid || m_axis_tready; s_axis_tready = enable.
REQ-017 SHALL have a fixed latency of 3 enabled cycles from input acceptance to output presentation.
REQ-018 SHALL keep a running autocorrelation P = sum over the last DELAY_L samples of r(n) * conj(r(n+DELAY_L)), computed with a 2*DELAY_L-deep delay line plus add-new/subtract-old running sums.
REQ-019 SHALL keep a running energy E = sum of |r(n+DELAY_L)|^2 over the same window.
REQ-020 SHALL size P and E at 2*SAMPLE_W + log2(DELAY_L) + 1 bits, with no overflow and no truncation.
REQ-021 SHALL compute metric M = |Re P| + |Im P|, unsigned.
REQ-022 SHALL define above = (M >= (E*cfg_threshold) >> 16) && (E != 0) && (warm-up complete).
REQ-023 SHALL complete warm-up after 2*DELAY_L accepted samples following reset.
REQ-024 SHALL implement FSM state SEARCH: on above, go to PLATEAU with run = 1.
REQ-025 SHALL implement FSM state PLATEAU: on above, run++; on !above, go to SEARCH; when run reaches MIN_PLATEAU, go to FRAME, latch cfg_packet_size and pulse detect_pulse.
REQ-026 SHALL implement FSM state FRAME: count output samples; after the latched length, go to WAIT_LOW.
REQ-027 SHALL implement FSM state WAIT_LOW: on !above, go to SEARCH.
REQ-028 SHALL advance the FSM only on accepted samples.
REQ-029 SHALL apply cfg_output_select and cfg_threshold immediately, while frame length comes only from the value latched on FRAME entry.
REQ-030 SHALL implement output modes:
- Mode 0: every sample is output; samples outside FRAME are zeroed.
- Mode 1: only FRAME samples are output; other samples are dropped with no output beat.
- Mode 2: outputs bits 63:32 of M, zero-extended to 64 bits.
- Mode 3: outputs bits 31:0 of M.
REQ-031 SHALL drive m_axis_tlast on the last FRAME sample in mode 1, and every cfg_packet_size output beats in modes 0, 2 and 3.
REQ-032 SHALL resolve a FRAME end coinciding with above by going to WAIT_LOW; no back-to-back retrigger.

Reset
REQ-033 SHALL clear on rst the delay line, sums, counters and warm-up counter, and put the FSM in SEARCH.
REQ-034 SHALL drive on rst m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, detect_pulse = 0 and status_detect_count = 0.
REQ-035 SHALL let reset asserted mid-frame abort the frame with no tlast emitted, and restart warm-up.

Configuration
REQ-036 SHALL, when macro SCHMIDL_COX_DETECT_CNT_EN is defined, make status_detect_count a 32-bit counter that increments per detect_pulse and saturates at 0xFFFFFFFF.
REQ-037 SHALL, when SCHMIDL_COX_DETECT_CNT_EN is undefined, tie status_detect_count to 0 and synthesise no counter logic.

Verification
REQ-038 SHALL cover reset: assert rst mid-stream -> next cycle m_axis_tvalid = 0 and detect_pulse = 0; first output appears after 3 cycles.
REQ-039 SHALL cover zero input: 1000 zero samples, mode 0 -> 1000 zero beats; detect_pulse never asserts because E = 0.
REQ-040 SHALL cover constant input: I = 0x0100, Q = 0, DELAY_L = 64, mode 3 -> after warm-up each beat equals 0x00400000; mode 2 beats equal 0.
REQ-041 SHALL cover detection: constant preamble, cfg_threshold = 0x8000, cfg_packet_size = 256, mode 1 -> exactly 256 beats with tlast on beat 256; one detect_pulse, 16 accepted samples after warm-up; count = 1 with the macro defined.
REQ-042 SHALL cover no detection: random noise with cfg_threshold = 0xFFFF -> no detect_pulse and no mode-1 output.
REQ-043 SHALL cover backpressure: m_axis_tready random at 25% stall -> output data and tlast sequence bit-identical to the no-stall run; no accepted samples lost.
